// File: rtl/shared_net_arb_pkg.sv
// shared_net_arb_pkg: shared types and width helpers for the shared-net arbiter.
package shared_net_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int DEF_N = 4;
  localparam int DEF_IDX_W = idx_w(DEF_N);
endpackage

// File: rtl/shared_net_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request scanning cyclically from ptr.
module rr_pick
  import shared_net_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);
  int j;
  always_comb begin
    any = |req;
    idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) idx = IW'(j);
    end
  end
endmodule

// File: rtl/shared_net_arbiter.sv
// shared_net_arbiter: round-robin owner of one shared net with bounded hold and one-cycle turnaround.
// Optional ARB_CONTENTION_CNT_EN adds a saturating count of cycles with two or more requests.
module shared_net_arbiter
  import shared_net_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1,
  parameter int MAX_HOLD = 8,
  parameter logic [W-1:0] IDLE_VAL = '0,
  localparam int IW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data_in,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   owner,
  output logic [W-1:0]    bus_out,
`ifdef ARB_CONTENTION_CNT_EN
  output logic [15:0]     contention_cnt,
`endif
  output logic            bus_valid
);
  localparam int HW = idx_w(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  state_t state, state_n;
  logic [N-1:0] grant_n;
  logic [IW-1:0] owner_n, rr_ptr, ptr_n, pick, unused_other_idx;
  logic [W-1:0] bus_n;
  logic valid_n, any, other_any, timeout;
  logic [HW-1:0] hold_cnt, hold_n;
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .any(any),
    .idx(pick)
  );
  // Only "is anyone else waiting" matters for the forced handover.
  rr_pick #(.N(N), .IW(IW)) u_other (
    .req(req & ~(N'(1) << owner)),
    .ptr(owner),
    .any(other_any),
    .idx(unused_other_idx)
  );
  assign timeout = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    bus_n = bus_out;
    valid_n = bus_valid;
    ptr_n = rr_ptr;
    hold_n = hold_cnt;
    if (state == GRANT) begin
      if (!req[owner] || (timeout && other_any)) begin
        state_n = TURN;
        grant_n = '0;
        owner_n = '0;
        bus_n = IDLE_VAL;
        valid_n = 1'b0;
        hold_n = '0;
        ptr_n = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
      end else begin
        bus_n = data_in[int'(owner)*W +: W];
        hold_n = timeout ? '0 : hold_cnt + 1'b1;
      end
    end else begin
      state_n = any ? GRANT : IDLE;
      grant_n = any ? N'(1) << pick : '0;
      owner_n = any ? pick : '0;
      bus_n = any ? data_in[int'(pick)*W +: W] : IDLE_VAL;
      valid_n = any;
      hold_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      bus_out <= IDLE_VAL;
      bus_valid <= 1'b0;
      rr_ptr <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      bus_out <= bus_n;
      bus_valid <= valid_n;
      rr_ptr <= ptr_n;
      hold_cnt <= hold_n;
    end
  end
`ifdef ARB_CONTENTION_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) contention_cnt <= '0;
    else if ($countones(req) >= 2 && contention_cnt != 16'hFFFF) contention_cnt <= contention_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_shared_net_arbiter.sv
// tb_shared_net_arbiter: table-driven vectors plus hand sequences for rotation, hold, wrap and reset.
module tb_shared_net_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, data_in, grant;
  logic [1:0] owner;
  logic bus_out, bus_valid;
`ifdef ARB_CONTENTION_CNT_EN
  logic [15:0] contention_cnt;
`endif
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  shared_net_arbiter #(.N(4), .W(1), .MAX_HOLD(8), .IDLE_VAL(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .data_in(data_in),
    .grant(grant),
    .owner(owner),
    .bus_out(bus_out),
`ifdef ARB_CONTENTION_CNT_EN
    .contention_cnt(contention_cnt),
`endif
    .bus_valid(bus_valid)
  );
  typedef struct packed {
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] g;
    logic [1:0] o;
    logic b;
    logic v;
  } vec_t;
  vec_t tbl [18];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    data_in = '0;
    step();
    rst = 1'b0;
  endtask
  function automatic logic [31:0] outs();
    return {24'd0, grant, owner, bus_out, bus_valid};
  endfunction
  function automatic logic [31:0] exp_outs(logic [3:0] g, logic [1:0] o, logic b, logic v);
    return {24'd0, g, o, b, v};
  endfunction
  initial begin
    int owners [5];
    logic [3:0] d;
    for (int i = 0; i < 5; i++) tbl[i] = {4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[5]  = {4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[6]  = {4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[7]  = {4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1};
    tbl[8]  = {4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[9]  = {4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[10] = {4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[11] = {4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[12] = {4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[13] = {4'b0011, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[14] = {4'b0010, 4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[15] = {4'b0010, 4'b1101, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[16] = {4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[17] = {4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    owners = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = '0;
    data_in = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_outs", outs(), exp_outs(4'b0000, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < 18; i++) begin
      req = tbl[i].req;
      data_in = tbl[i].data;
      step();
      chk($sformatf("vec%0d", i), outs(), exp_outs(tbl[i].g, tbl[i].o, tbl[i].b, tbl[i].v));
    end
    // all four requesting: 8-cycle tenures, one dead cycle between owners
    do_reset();
    d = 4'b1010;
    req = 4'b1111;
    data_in = d;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        chk($sformatf("rot_t%0d_c%0d", t, c), outs(),
            exp_outs(4'b0001 << owners[t], 2'(owners[t]), d[owners[t]], 1'b1));
      end
      if (t == 4) req = '0;
      step();
      chk($sformatf("rot_dead%0d", t), outs(), exp_outs(4'b0000, 2'd0, 1'b0, 1'b0));
    end
    step();
    chk("rot_idle", outs(), exp_outs(4'b0000, 2'd0, 1'b0, 1'b0));
    // lone requester is never forced off
    do_reset();
    req = 4'b0010;
    data_in = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("lone_c%0d", c), outs(), exp_outs(4'b0010, 2'd1, 1'b1, 1'b1));
    end
    req = '0;
    step();
    step();
    // owner 3 releases; rr_ptr must wrap to 0 so requester 0 outranks 3
    do_reset();
    req = 4'b1000;
    data_in = 4'b1001;
    step();
    chk("wrap_own3", outs(), exp_outs(4'b1000, 2'd3, 1'b1, 1'b1));
    req = 4'b0001;
    step();
    chk("wrap_turn", outs(), exp_outs(4'b0000, 2'd0, 1'b0, 1'b0));
    req = 4'b1001;
    step();
    chk("wrap_own0", outs(), exp_outs(4'b0001, 2'd0, 1'b1, 1'b1));
    req = '0;
    step();
    step();
    // reset mid-grant restores rr_ptr to 0
    do_reset();
    req = 4'b0010;
    data_in = 4'b0100;
    step();
    chk("rst_own1", outs(), exp_outs(4'b0010, 2'd1, 1'b0, 1'b1));
    req = 4'b0000;
    step();
    req = 4'b0100;
    step();
    step();
    step();
    chk("rst_grant3", outs(), exp_outs(4'b0100, 2'd2, 1'b1, 1'b1));
    rst = 1'b1;
    step();
    chk("rst_mid", outs(), exp_outs(4'b0000, 2'd0, 1'b0, 1'b0));
    rst = 1'b0;
    req = 4'b1111;
    data_in = 4'b0001;
    step();
    chk("rst_ptr0", outs(), exp_outs(4'b0001, 2'd0, 1'b1, 1'b1));
`ifdef ARB_CONTENTION_CNT_EN
    do_reset();
    chk("cnt_reset", 32'(contention_cnt), 32'd0);
    req = 4'b0011;
    for (int c = 0; c < 10; c++) step();
    req = 4'b0001;
    step();
    chk("cnt_ten", 32'(contention_cnt), 32'd10);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (!$onehot0(grant) || (bus_valid != (grant != 0))) begin
        bad++;
        $display("FAIL invariant: grant %b bus_valid %b at %0t", grant, bus_valid, $time);
      end
    end
  end
endmodule
